// File: rtl/a5_keystream_packer.sv
`timescale 1ns/1ps
// a5_keystream_packer: runs an A5/1 keystream generator and packs its
// serial output LSB-first into WORD_WIDTH-bit words with a per-load length
// limit. Words are queued in a show-ahead FIFO with a {last, bits, data} entry.

// ---------------------------------------------------------------------------
// a5_generator: A5/1 keystream generator with a load/stall interface.
// The key stream is bit i = bit (i%8) of byte i/8, where byte 0 is key_i[63:56].
// The frame stream is bit i = frame_i[i].
// ---------------------------------------------------------------------------
module a5_generator (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_i,
    input  logic        stall_i,
    input  logic [63:0] key_i,
    input  logic [21:0] frame_i,
    output logic        valid_o,
    output logic        bit_o
);
    // The sequencer steps through four phases:
    //   0..63   : key mixing.
    //   64..85  : frame mixing.
    //   86..186 : 100 discarded majority steps, plus one pre-step so that the
    //             first keystream bit is already on bit_o.
    //   187     : output phase. A majority step is taken per consumed bit.
    localparam logic [7:0] KEY_END   = 8'd64;
    localparam logic [7:0] MIX_END   = 8'd86;
    localparam logic [7:0] OUT_PHASE = 8'd187;

    logic [18:0] r1_q, r1_d, r1_step;
    logic [21:0] r2_q, r2_d, r2_step;
    logic [22:0] r3_q, r3_d, r3_step;
    logic [7:0]  cnt_q, cnt_d;
    logic [63:0] key_q;
    logic [21:0] frame_q;
    logic        maj;
    logic        in_bit;

    // Next LFSR state: regular clocking during mixing, majority clocking afterwards.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        r1_d    = r1_q;
        r2_d    = r2_q;
        r3_d    = r3_q;
        cnt_d   = cnt_q;
        in_bit  = 1'b0;
        maj     = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) | (r2_q[10] & r3_q[10]);
        r1_step = {r1_q[17:0], r1_q[18] ^ r1_q[17] ^ r1_q[16] ^ r1_q[13]};
        r2_step = {r2_q[20:0], r2_q[21] ^ r2_q[20]};
        r3_step = {r3_q[21:0], r3_q[22] ^ r3_q[21] ^ r3_q[20] ^ r3_q[7]};
        if (cnt_q < KEY_END) begin
            in_bit = key_q[{~cnt_q[5:3], cnt_q[2:0]}];
        end else if (cnt_q < MIX_END) begin
            in_bit = frame_q[cnt_q[4:0]];
        end
        if (!stall_i) begin
            if (cnt_q < MIX_END) begin
                r1_d = r1_step ^ {18'd0, in_bit};
                r2_d = r2_step ^ {21'd0, in_bit};
                r3_d = r3_step ^ {22'd0, in_bit};
            end else begin
                if (r1_q[8] == maj) r1_d = r1_step;
                if (r2_q[10] == maj) r2_d = r2_step;
                if (r3_q[10] == maj) r3_d = r3_step;
            end
            if (cnt_q != OUT_PHASE) cnt_d = cnt_q + 8'd1;
        end
    end

    // State registers. A load restarts mixing from an all-zero LFSR state.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            r1_q    <= '0;
            r2_q    <= '0;
            r3_q    <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
            frame_q <= '0;
        end else if (load_i) begin
            r1_q    <= '0;
            r2_q    <= '0;
            r3_q    <= '0;
            cnt_q   <= '0;
            key_q   <= key_i;
            frame_q <= frame_i;
        end else begin
            r1_q  <= r1_d;
            r2_q  <= r2_d;
            r3_q  <= r3_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid_o = (cnt_q == OUT_PHASE);
    assign bit_o   = r1_q[18] ^ r2_q[21] ^ r3_q[22];
endmodule

// ---------------------------------------------------------------------------
// a5_fifo: a show-ahead FIFO with a synchronous flush.
// A write into a full FIFO is accepted when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module a5_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_rd, do_wr;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update. A flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; entries are only visible once written.
        if (do_wr && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
endmodule

// ---------------------------------------------------------------------------
// a5_keystream_packer: the top level.
// ---------------------------------------------------------------------------
module a5_keystream_packer #(
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          load,
    input  logic [63:0]                   key,
    input  logic [21:0]                   frame,
    input  logic [LEN_WIDTH-1:0]          num_bits,
    input  logic                          rd_en,
    output logic [WORD_WIDTH-1:0]         data_out,
    output logic                          data_last,
    output logic [$clog2(WORD_WIDTH):0]   data_bits,
    output logic                          empty,
    output logic                          busy,
    output logic                          done
);
    localparam int BW = $clog2(WORD_WIDTH) + 1;
    localparam int EW = 1 + BW + WORD_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_TAIL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic                  unlim_q, unlim_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         fill_q, fill_d;

    logic                  gen_valid, gen_bit, stall, capture;
    logic                  word_full, limit_hit, can_wr, wr_en;
    logic                  fifo_full, fifo_empty;
    logic [EW-1:0]         fifo_head;

    assign word_full = (fill_q == BW'(WORD_WIDTH));
    assign limit_hit = !unlim_q && (count_q == '0);
    assign stall     = word_full || fifo_full || (state_q != S_RUN) || limit_hit;
    assign capture   = (state_q == S_RUN) && gen_valid && !stall;
    // A full FIFO still takes the write when the consumer pops in the same cycle.
    assign can_wr    = !fifo_full || (rd_en && !fifo_empty);

    a5_generator u_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (load),
        .stall_i (stall),
        .key_i   (key),
        .frame_i (frame),
        .valid_o (gen_valid),
        .bit_o   (gen_bit)
    );

    // Packer and FSM next state. A load overrides everything else in its cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unlim_d = unlim_q;
        shift_d = shift_q;
        fill_d  = fill_q;
        wr_en   = 1'b0;
        if (load) begin
            state_d = S_RUN;
            count_d = num_bits;
            unlim_d = (num_bits == '0);
            shift_d = '0;
            fill_d  = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (word_full) begin
                        if (can_wr) begin
                            wr_en   = 1'b1;
                            shift_d = '0;
                            fill_d  = '0;
                            if (limit_hit) state_d = S_DONE;
                        end
                    end else if (limit_hit) begin
                        state_d = (fill_q != '0) ? S_TAIL : S_DONE;
                    end else if (capture) begin
                        shift_d[fill_q[BW-2:0]] = gen_bit;
                        fill_d = fill_q + 1'b1;
                        if (!unlim_q) count_d = count_q - 1'b1;
                    end
                end
                S_TAIL: begin
                    if (can_wr) begin
                        wr_en   = 1'b1;
                        shift_d = '0;
                        fill_d  = '0;
                        state_d = S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Packer and FSM registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            unlim_q <= 1'b0;
            shift_q <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            unlim_q <= unlim_d;
            shift_q <= shift_d;
            fill_q  <= fill_d;
        end
    end

    a5_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush_i   (load),
        .wr_en_i   (wr_en),
        .wr_data_i ({limit_hit, fill_q, shift_q}),
        .rd_en_i   (rd_en),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // When the FIFO is empty, the head is forced to zero so no stale entry is shown.
    assign data_out  = fifo_empty ? '0 : fifo_head[WORD_WIDTH-1:0];
    assign data_bits = fifo_empty ? '0 : fifo_head[WORD_WIDTH +: BW];
    assign data_last = fifo_empty ? 1'b0 : fifo_head[EW-1];
    assign empty     = fifo_empty;
    assign busy      = (state_q == S_RUN) || (state_q == S_TAIL);
    assign done      = (state_q == S_DONE);
endmodule

// File: tb/tb_a5_keystream_packer.sv
`timescale 1ns/1ps
// Testbench for a5_keystream_packer. The reference model produces the A5/1
// keystream by direct simulation of the three registers, and then slices it
// into the expected words.
module tb_a5_keystream_packer;
    localparam int W  = 32;
    localparam int SW = 8;

    logic clk = 1'b0;
    logic reset_n;

    logic          load, rd_en;
    logic [63:0]   key;
    logic [21:0]   frame;
    logic [15:0]   num_bits;
    logic [W-1:0]  data_out;
    logic          data_last, empty, busy, done;
    logic [5:0]    data_bits;

    logic          s_load, s_rd_en;
    logic [63:0]   s_key;
    logic [21:0]   s_frame;
    logic [15:0]   s_num_bits;
    logic [SW-1:0] s_data_out;
    logic          s_data_last, s_empty, s_busy, s_done;
    logic [3:0]    s_data_bits;

    int n_checks = 0;
    int n_errors = 0;

    bit           ref_ks [0:1023];
    logic [W-1:0] got_w  [0:63];

    always #5 clk = ~clk;

    a5_keystream_packer #(.WORD_WIDTH(W), .FIFO_DEPTH(4), .LEN_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .key(key), .frame(frame),
        .num_bits(num_bits), .rd_en(rd_en), .data_out(data_out), .data_last(data_last),
        .data_bits(data_bits), .empty(empty), .busy(busy), .done(done)
    );

    a5_keystream_packer #(.WORD_WIDTH(SW), .FIFO_DEPTH(2), .LEN_WIDTH(16)) dut_s (
        .clk(clk), .reset_n(reset_n), .load(s_load), .key(s_key), .frame(s_frame),
        .num_bits(s_num_bits), .rd_en(s_rd_en), .data_out(s_data_out), .data_last(s_data_last),
        .data_bits(s_data_bits), .empty(s_empty), .busy(s_busy), .done(s_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // The A5/1 reference: 64 key bits and 22 frame bits are each mixed in
    // after a regular step, then 100 majority steps are taken, then each output
    // bit is produced by a majority step followed by reading the register MSBs.
    task automatic gen_ref(input logic [63:0] k, input logic [21:0] f, input int nbits);
        int unsigned r [3];
        int unsigned len [3];
        int unsigned mid [3];
        int unsigned tap [3];
        int unsigned b, m, fb;
        int unsigned c [3];
        len = '{19, 22, 23};
        mid = '{8, 10, 10};
        tap = '{32'h072000, 32'h300000, 32'h700080};
        r   = '{0, 0, 0};
        for (int i = 0; i < 86; i++) begin
            if (i < 64) b = k[56 - 8 * (i / 8) + (i % 8)];
            else        b = f[i - 64];
            for (int j = 0; j < 3; j++) begin
                fb   = $countones(r[j] & tap[j]) % 2;
                r[j] = (((r[j] << 1) | fb) & ((1 << len[j]) - 1)) ^ b;
            end
        end
        for (int i = 0; i < 100 + nbits; i++) begin
            for (int j = 0; j < 3; j++) c[j] = (r[j] >> mid[j]) & 1;
            m = (c[0] + c[1] + c[2] >= 2) ? 1 : 0;
            for (int j = 0; j < 3; j++) begin
                if (c[j] == m) begin
                    fb   = $countones(r[j] & tap[j]) % 2;
                    r[j] = ((r[j] << 1) | fb) & ((1 << len[j]) - 1);
                end
            end
            if (i >= 100) ref_ks[i - 100] = ((r[0] >> 18) ^ (r[1] >> 21) ^ (r[2] >> 22)) & 1;
        end
    endtask

    task automatic do_load(input logic [63:0] k, input logic [21:0] f, input logic [15:0] n);
        key = k; frame = f; num_bits = n; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // This task pops nwords words from the main instance and checks them against the model.
    task automatic drain(input string tag, input logic [63:0] k, input logic [21:0] f,
                         input int n, input int nwords, input int gap, input int budget);
        int total;
        total = (n == 0) ? nwords * W : n;
        gen_ref(k, f, total);
        for (int w = 0; w < nwords; w++) begin
            int nb;
            int c;
            logic [W-1:0] exp_d;
            logic exp_last;
            nb = total - w * W;
            if (nb > W) nb = W;
            exp_d = '0;
            for (int b = 0; b < nb; b++) exp_d[b] = ref_ks[w * W + b];
            exp_last = (n != 0) && (w * W + nb == n);
            c = 0;
            while (empty && c < budget) begin @(negedge clk); c++; end
            check($sformatf("%s_avail%0d", tag, w), empty, 0);
            check($sformatf("%s_data%0d", tag, w), data_out, exp_d);
            check($sformatf("%s_bits%0d", tag, w), data_bits, nb);
            check($sformatf("%s_last%0d", tag, w), data_last, exp_last);
            got_w[w] = data_out;
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [119:0] a2b, b2a;
        bit           vec [0:227];
        logic [W-1:0] cw;
        logic [63:0]  rk;
        logic [21:0]  rf;
        int           rn, c;

        reset_n = 1'b0; load = 1'b0; rd_en = 1'b0; key = '0; frame = '0; num_bits = '0;
        s_load = 1'b0; s_rd_en = 1'b0; s_key = '0; s_frame = '0; s_num_bits = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_empty", empty, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", data_out, 0);
        check("rst_last", data_last, 0);
        check("rst_bits", data_bits, 0);

        // The published keystream vector.
        do_load(64'h1223456789ABCDEF, 22'h134, 16'd228);
        check("vec_busy", busy, 1);
        drain("vec", 64'h1223456789ABCDEF, 22'h134, 228, 8, 0, 2000);
        a2b = 120'h534EAA582FE8151AB6E1855A728C00;
        b2a = 120'h24FD35A35D5FB6526D32F906DF1AC0;
        for (int i = 0; i < 114; i++) begin
            vec[i]       = a2b[119 - i];
            vec[114 + i] = b2a[119 - i];
        end
        for (int w = 0; w < 8; w++) begin
            cw = '0;
            for (int b = 0; b < W; b++) if (w * W + b < 228) cw[b] = vec[w * W + b];
            check($sformatf("vec_const%0d", w), got_w[w], cw);
        end
        check("vec_done", done, 1);
        check("vec_busy_end", busy, 0);

        // Backpressure: the FIFO fills and the generator holds; every later pop finds a word waiting.
        do_load(64'h1223456789ABCDEF, 22'h134, 16'd228);
        repeat (600) @(negedge clk);
        check("bp_empty", empty, 0);
        check("bp_busy", busy, 1);
        check("bp_done", done, 0);
        drain("bp", 64'h1223456789ABCDEF, 22'h134, 228, 8, 50, 2);
        check("bp_done_end", done, 1);

        // The length is an exact multiple of the word width.
        do_load(64'h1223456789ABCDEF, 22'h134, 16'd64);
        drain("mult", 64'h1223456789ABCDEF, 22'h134, 64, 2, 0, 2000);
        repeat (100) @(negedge clk);
        check("mult_no_tail", empty, 1);
        check("mult_done", done, 1);

        // A reload in the middle of a stream.
        do_load(64'h1223456789ABCDEF, 22'h134, 16'd228);
        drain("pre", 64'h1223456789ABCDEF, 22'h134, 228, 3, 0, 2000);
        do_load(64'h1223456789ABCDEF, 22'h135, 16'd228);
        check("reload_empty", empty, 1);
        check("reload_done", done, 0);
        drain("reload", 64'h1223456789ABCDEF, 22'h135, 228, 8, 0, 2000);
        check("reload_done_end", done, 1);

        // Randomized limited runs with random consumer gaps.
        for (int t = 0; t < 3; t++) begin
            rk = {$urandom, $urandom};
            rf = 22'($urandom);
            rn = $urandom_range(1, 300);
            do_load(rk, rf, 16'(rn));
            drain($sformatf("rnd%0d", t), rk, rf, rn, (rn + W - 1) / W, $urandom_range(0, 40), 2000);
            c = 0;
            while (!done && c < 50) begin @(negedge clk); c++; end
            check($sformatf("rnd%0d_done", t), done, 1);
        end

        // Unlimited mode, followed by a reset in the middle of a word.
        rk = {$urandom, $urandom};
        rf = 22'($urandom);
        do_load(rk, rf, 16'd0);
        drain("unl", rk, rf, 0, 20, 0, 2000);
        check("unl_busy", busy, 1);
        check("unl_done", done, 0);
        repeat (10) @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("arst_empty", empty, 1);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_last", data_last, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_empty", empty, 1);
        check("idle_done", done, 0);

        // The narrow instance: an 8-bit word width with a 2-deep FIFO.
        rk = {$urandom, $urandom};
        rf = 22'($urandom);
        s_key = rk; s_frame = rf; s_num_bits = 16'd13; s_load = 1'b1;
        @(negedge clk);
        s_load = 1'b0;
        gen_ref(rk, rf, 13);
        for (int w = 0; w < 2; w++) begin
            logic [SW-1:0] exp_d;
            int nb;
            nb = (w == 0) ? 8 : 5;
            exp_d = '0;
            for (int b = 0; b < nb; b++) exp_d[b] = ref_ks[w * SW + b];
            c = 0;
            while (s_empty && c < 2000) begin @(negedge clk); c++; end
            check($sformatf("nar_avail%0d", w), s_empty, 0);
            check($sformatf("nar_data%0d", w), s_data_out, exp_d);
            check($sformatf("nar_bits%0d", w), s_data_bits, nb);
            check($sformatf("nar_last%0d", w), s_data_last, w == 1);
            s_rd_en = 1'b1;
            @(negedge clk);
            s_rd_en = 1'b0;
        end
        repeat (5) @(negedge clk);
        check("nar_done", s_done, 1);
        check("nar_empty", s_empty, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/a5_keystream_packer.md
Name: a5_keystream_packer

Overview:
- Parametrised successor to the single-width A5/1 keystream buffer.
- Runs the existing A5Generator and packs its serial keystream into WORD_WIDTH-bit words, LSB-first.
- Words are queued in a show-ahead FIFO built on the existing Fifo, FIFO_DEPTH deep.
- New over the previous generation: a per-load keystream length limit (default 228 bits, one GSM frame pair), a zero-padded partial final word, and last/valid-bit sideband on every word. Sits between key/frame configuration and the cipher datapath consumer.

Parameters:
- WORD_WIDTH, 32, output word width in bits; legal range 8..64.
- FIFO_DEPTH, 4, FIFO entries; power of two, at least 2.
- LEN_WIDTH, 16, width of the num_bits length field.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- load  in  1  1-cycle pulse: restart generator with key/frame, flush FIFO and packer, capture num_bits.
- key  in  64  session key; sampled by A5Generator on load.
- frame  in  22  frame number; sampled by A5Generator on load.
- num_bits  in  LEN_WIDTH  keystream bits to produce; sampled on load; 0 = unlimited.
- rd_en  in  1  pop the head word; ignored while empty=1.
- data_out  out  WORD_WIDTH  head word, valid while empty=0.
- data_last  out  1  head word is the final word of this load.
- data_bits  out  clog2(WORD_WIDTH)+1  count of valid bits in the head word (1..WORD_WIDTH).
- empty  out  1  FIFO empty.
- busy  out  1  keystream generation in progress.
- done  out  1  all num_bits bits have been written into the FIFO.

Behaviour:
- Reset:
  - All outputs 0, except empty=1.
  - FSM enters IDLE and the packer is cleared.
  - Reset mid-operation discards all state; nothing resumes.
- FSM states:
  - IDLE: after reset; busy=0, done=0.
  - RUN: entered the cycle after load; busy=1.
  - TAIL: limit reached with 1..WORD_WIDTH-1 bits pending; busy=1.
  - DONE: busy=0, done=1; stays until the next load.
- load handling:
  - load in any state flushes the FIFO and packer, clears done, latches num_bits into a down-counter, enters RUN.
  - load has priority over rd_en and over any pending write in the same cycle.
  - A rd_en in the load cycle pops nothing.
- Bit capture:
  - In RUN, one bit is captured per cycle when generator valid=1 and the generator is not stalled.
  - The k-th captured bit of a word goes to bit k; bit 0 is the first keystream bit.
  - Each capture decrements the counter (unlimited mode: no count).
- Generator stall is asserted while any of these holds:
  - a completed word is awaiting its write;
  - FIFO is full;
  - state is TAIL or DONE;
  - the counter is 0 in limited mode.
  - While stalled, no bits are captured or lost.
- Word write:
  - When WORD_WIDTH bits are packed, the word is written on the next cycle with FIFO not full.
  - That write cycle captures no bit, so a full word costs WORD_WIDTH+1 cycles at best.
  - Written entry = {last, bits, data}.
- Limit reached:
  - Counter hits 0 with a complete word: write it with last=1, bits=WORD_WIDTH, go DONE.
  - Counter hits 0 with a partial word: go TAIL, write with upper bits zero, last=1, bits=count, go DONE.
- FIFO full: the word is held, and the generator stays stalled until an entry is popped.
- Unlimited mode: data_last never asserts; done stays 0.
- Same-cycle events:
  - rd_en while full plus a pending write in the same cycle: both occur.
  - rd_en while empty: no effect, no underflow.
- done asserts the cycle after the final word enters the FIFO. It is independent of consumer drain.
- Generator warm-up cycles (valid=0) produce no captures and no counter change.

Test Plan:
- Keystream vector:
  - Stimulus: reset; load key=0x1223456789ABCDEF, frame=0x134, num_bits=228; drain with rd_en held 1.
  - Expected: 8 words; words 0..6 have bits=32, last=0; word 7 has bits=4, last=1, data[31:4]=0.
  - Concatenated bits equal the 228-bit reference keystream for this key/frame; downlink half starts 0x534EAA58..., MSB of the hex string = bit 0 of word 0.
  - done=1 after word 7 is written.
- Backpressure:
  - Stimulus: same load with rd_en=0.
  - Expected: empty deasserts, FIFO fills to 4; no further captures; busy stays 1.
  - Then pop one word every 50 cycles; the full word sequence is identical to the first scenario.
- Exact multiple:
  - Stimulus: num_bits=64.
  - Expected: exactly 2 words; word 1 has last=1, bits=32; no TAIL padding word.
- Mid-stream reload:
  - Stimulus: load at word 3 of a 228-bit run, with a new frame=0x135.
  - Expected: the next cycle has empty=1 and done=0; subsequent words match the 0x135 keystream from bit 0.
- Unlimited and reset:
  - Stimulus: num_bits=0, drain 20 words.
  - Expected: last=0 throughout, busy=1.
  - Then assert reset_n=0 mid-word: empty=1, busy=0, done=0, data_last=0 immediately; stays IDLE after release.
- Parameter sweep: WORD_WIDTH=8, FIFO_DEPTH=2, num_bits=13 -> word 0 has bits=8; word 1 has bits=5, last=1, data[7:5]=0.
